pc_sequencer: RTL and testbench

Program-counter controller for the single-issue RISC-V core. It owns the PC register, fetches each instruction from instruction memory over a request/valid handshake, and presents the instruction to decode/ALU. It waits for the ALU zero flag, then commits the next PC: PC+4, or PC+B-offset for a taken branch. It sits between instruction memory and the fetch-side next-PC selection logic, and also keeps a retired-instruction count.

---
 rtl/rv_core_pkg.sv | 19 +
 rtl/pc_next_sel.sv | 28 ++
 rtl/pc_sequencer.sv | 103 ++++++++++
 tb/tb_pc_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/rv_core_pkg.sv
// Shared core definitions: opcode constants, sequencer state type and B-type
// immediate extraction, reused by decode.
package rv_core_pkg;

  localparam int OPC_W = 7;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } seq_state_t;

  // Sign-extended B-type offset; bit 0 is always zero.
  function automatic logic [31:0] b_imm(input logic [31:0] instr);
    return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: sequential PC+4, or PC+B-offset when a branch is taken
// (this core takes a branch when the ALU zero flag is clear).
module pc_next_sel
  import rv_core_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [31:0] i_instr,
  input  logic        i_cero,
  output logic [31:0] o_next_pc,
  output logic        o_misaligned
);

  logic w_taken;

  assign w_taken = (i_instr[OPC_W-1:0] == OPC_BRANCH) && !i_cero;

  // NOTE: every output gets a default at the top of always_comb so no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    o_next_pc    = i_pc + 32'd4;
    o_misaligned = 1'b0;
    if (w_taken) begin
      o_next_pc    = i_pc + b_imm(i_instr);
      o_misaligned = (o_next_pc[1:0] != 2'b00);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// PC register, fetch handshake, branch commit and retired-instruction counter
// for the single-issue core.
module pc_sequencer
  import rv_core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        alu_done,
  input  logic        cero,
  input  logic        stall,
  output logic [31:0] pc,
  output logic [31:0] instret,
  output logic        misalign_err
);

  seq_state_t  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_instret;
  logic        r_misalign;
  logic        r_done_q;
  logic        r_cero_q;

  logic        w_done_any;
  logic        w_cero;
  logic        w_commit;
  logic [31:0] w_next_pc;
  logic        w_misaligned;

  // A live alu_done carries the freshest flag; otherwise use the one captured
  // while the commit was stalled.
  assign w_done_any = alu_done | r_done_q;
  assign w_cero     = alu_done ? cero : r_cero_q;
  assign w_commit   = (r_state == ST_EXEC) && w_done_any && !stall;

  pc_next_sel u_next_sel (
    .i_pc        (r_pc),
    .i_instr     (r_instr),
    .i_cero      (w_cero),
    .o_next_pc   (w_next_pc),
    .o_misaligned(w_misaligned)
  );

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_FETCH;
      r_pc       <= RESET_PC;
      r_instr    <= 32'd0;
      r_instret  <= 32'd0;
      r_misalign <= 1'b0;
      r_done_q   <= 1'b0;
      r_cero_q   <= 1'b0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (imem_valid) begin
            r_instr <= imem_rdata;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (w_commit) begin
            r_done_q <= 1'b0;
            if (w_misaligned) begin
              r_misalign <= 1'b1;
              r_state    <= ST_HALT;
            end else begin
              r_pc      <= w_next_pc;
              r_instret <= r_instret + 32'd1;
              r_state   <= ST_FETCH;
            end
          end else if (alu_done && !r_done_q) begin
            r_done_q <= 1'b1;
            r_cero_q <= cero;
          end
        end
        ST_HALT: begin
          r_state <= ST_HALT;
        end
        default: r_state <= ST_HALT;
      endcase
    end
  end

  assign imem_req     = (r_state == ST_FETCH);
  assign imem_addr    = r_pc;
  assign instr_valid  = (r_state == ST_EXEC);
  assign instr        = r_instr;
  assign pc           = r_pc;
  assign instret      = r_instret;
  assign misalign_err = r_misalign;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset state, sequential and branch commits,
// wrap-around, stalled-done capture and misaligned-branch halt.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req,   imem_req_b;
  logic [31:0] imem_addr,  imem_addr_b;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [31:0] instr,      instr_b;
  logic        instr_valid, instr_valid_b;
  logic        alu_done;
  logic        cero;
  logic        stall;
  logic [31:0] pc,         pc_b;
  logic [31:0] instret,    instret_b;
  logic        misalign_err, misalign_err_b;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] BR_P8    = 32'h0000_1463;
  localparam logic [31:0] BR_M4    = 32'hFE00_1EE3;
  localparam logic [31:0] BR_P2    = 32'h0000_1163;

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid),
    .alu_done(alu_done), .cero(cero), .stall(stall),
    .pc(pc), .instret(instret), .misalign_err(misalign_err)
  );

  pc_sequencer #(.RESET_PC(32'h0000_0100)) u_dut_b (
    .clk(clk), .rst(rst),
    .imem_req(imem_req_b), .imem_addr(imem_addr_b),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .instr(instr_b), .instr_valid(instr_valid_b),
    .alu_done(alu_done), .cero(cero), .stall(stall),
    .pc(pc_b), .instret(instret_b), .misalign_err(misalign_err_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Present a word after lat idle cycles; the FETCH->EXEC edge is the last tick.
  task automatic fetch(input logic [31:0] w, input int lat);
    imem_valid = 1'b0;
    repeat (lat) tick();
    imem_valid = 1'b1;
    imem_rdata = w;
    tick();
    imem_valid = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
  endtask

  task automatic execute(input logic z, input int lat);
    alu_done = 1'b0;
    repeat (lat) tick();
    alu_done = 1'b1;
    cero     = z;
    tick();
    alu_done = 1'b0;
    cero     = ~z;
  endtask

  task automatic run(input logic [31:0] w, input logic z);
    fetch(w, 0);
    execute(z, 0);
  endtask

  initial begin
    imem_valid = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    alu_done   = 1'b0;
    cero       = 1'b0;
    stall      = 1'b0;
    do_reset();

    // Reset state, including the instance built with RESET_PC=0x100.
    check("rst_pc",        pc,            32'h0);
    check("rst_req",       imem_req,      32'd1);
    check("rst_instret",   instret,       32'd0);
    check("rst_ivalid",    instr_valid,   32'd0);
    check("rst_instr",     instr,         32'd0);
    check("rst_misalign",  misalign_err,  32'd0);
    check("rstb_pc",       pc_b,          32'h100);
    check("rstb_addr",     imem_addr_b,   32'h100);
    check("rstb_req",      imem_req_b,    32'd1);

    // Sequential instruction with delayed imem_valid and alu_done.
    fetch(NOP, 2);
    check("nop_ivalid",    instr_valid,   32'd1);
    check("nop_instr",     instr,         NOP);
    check("nop_no_req",    imem_req,      32'd0);
    execute(1'b0, 1);
    check("nop_pc",        pc,            32'h4);
    check("nop_instret",   instret,       32'd1);
    check("nop_addr",      imem_addr,     32'h4);
    check("nop_req",       imem_req,      32'd1);

    for (int i = 0; i < 3; i++) run(NOP, 1'b0);
    check("walk_pc",       pc,            32'h10);

    // Taken branch +8, then not-taken branch.
    run(BR_P8, 1'b0);
    check("br_taken_pc",   pc,            32'h18);
    run(BR_P8, 1'b1);
    check("br_ntaken_pc",  pc,            32'h1C);
    check("br_instret",    instret,       32'd6);
    run(NOP, 1'b0);
    run(BR_M4, 1'b0);
    check("br_back_pc",    pc,            32'h1C);

    for (int i = 0; i < 9; i++) run(NOP, 1'b0);
    check("walk40_pc",     pc,            32'h40);
    check("walk40_instret", instret,      32'd17);

    // Misaligned target halts without commit.
    run(BR_P2, 1'b0);
    check("mis_err",       misalign_err,  32'd1);
    check("mis_req",       imem_req,      32'd0);
    check("mis_ivalid",    instr_valid,   32'd0);
    check("mis_pc",        pc,            32'h40);
    check("mis_instret",   instret,       32'd17);
    imem_valid = 1'b1;
    imem_rdata = NOP;
    alu_done   = 1'b1;
    repeat (3) tick();
    imem_valid = 1'b0;
    alu_done   = 1'b0;
    check("halt_pc",       pc,            32'h40);
    check("halt_req",      imem_req,      32'd0);
    check("halt_err",      misalign_err,  32'd1);

    do_reset();
    check("rec_err",       misalign_err,  32'd0);
    check("rec_pc",        pc,            32'h0);
    check("rec_req",       imem_req,      32'd1);

    // Backward branch from 0 wraps down, then a sequential step wraps up.
    run(BR_M4, 1'b0);
    check("wrap_dn_pc",    pc,            32'hFFFF_FFFC);
    run(NOP, 1'b0);
    check("wrap_up_pc",    pc,            32'h0);
    check("wrap_instret",  instret,       32'd2);

    // Done arrives while stalled with cero=0; flag flips before release and
    // no new done is given, so the captured value must decide the branch.
    fetch(BR_P8, 0);
    stall    = 1'b1;
    alu_done = 1'b1;
    cero     = 1'b0;
    tick();
    alu_done = 1'b0;
    cero     = 1'b1;
    tick();
    tick();
    check("stall_pc",      pc,            32'h0);
    check("stall_ivalid",  instr_valid,   32'd1);
    check("stall_instret", instret,       32'd2);
    stall = 1'b0;
    tick();
    check("rel_pc",        pc,            32'h8);
    check("rel_instret",   instret,       32'd3);
    repeat (3) tick();
    check("rel_once_pc",   pc,            32'h8);
    check("rel_once_cnt",  instret,       32'd3);

    // Reset while a fetch is outstanding restarts at RESET_PC.
    rst = 1'b1;
    imem_valid = 1'b1;
    imem_rdata = NOP;
    tick();
    rst = 1'b0;
    imem_valid = 1'b0;
    check("rst_fetch_pc",  pc,            32'h0);
    check("rst_fetch_req", imem_req,      32'd1);
    check("rst_fetch_iv",  instr_valid,   32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
